bcd5311_serial_conv: RTL and testbench
======================================

# bcd5311_serial_conv

Multi-digit, handshaked converter from BCD 5311 code to BCD 8421 code. It accepts a word of `DIGITS` 5311-coded nibbles and decodes one digit per clock, most-significant digit first. It flags undecodable digits per position and presents the result on a valid/ready output port. It sits between a 5311-coded source, such as a keypad or counter bank, and 8421-domain logic, such as display drivers or arithmetic.

## Interface
Parameters:
- `DIGITS`, default 4: number of 4-bit digits per word; must be ≥1.
- `BIN_W`, default 14: width of `out_bin`; must be ≥ ceil(DIGITS·log2(10)). Used only with `BCD_BIN_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  source has a word.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  4·DIGITS  5311 digits; nibble `i` is `in_data[4i+3:4i]`, and nibble DIGITS-1 is the MSD.
- `out_valid`  out  1  result word held.
- `out_ready`  in  1  sink takes the result.
- `out_data`  out  4·DIGITS  8421 digits, same nibble ordering as `in_data`.
- `out_err_mask`  out  DIGITS  bit `i` set means nibble `i` was undecodable.
- `out_err`  out  1  OR of `out_err_mask`.
- `out_bin`  out  BIN_W  binary value of the word. Exists only with `BCD_BIN_EN`.

## Operation
- Digit decode uses the weighted sum v = 5·b3 + 3·b2 + b1 + b0.
  - v ≤ 9: the digit is valid and the 8421 value is v. Redundant codes are accepted: 0010→1, 0110→4, 1000→5, 1010→6, 1110→9.
  - v = 10 (only code 1111): the digit is invalid. Its output nibble is 4'hF and its mask bit is set.
- The FSM has three states: IDLE, CONV and DONE.
  - IDLE: `in_ready`=1. When `in_valid`&&`in_ready`, capture `in_data` into a shift register, clear the digit counter, the accumulated result and the mask, then go to CONV.
  - CONV: each cycle, decode the current MSD-side nibble. Write its 8421 nibble into the result shift register and set its mask bit if invalid. Increment the counter. After DIGITS cycles, go to DONE.
  - DONE: `out_valid`=1, and all outputs are held stable. On `out_ready`=1, go to IDLE.
- `in_ready` is 0 in CONV and DONE. A word offered in those states is not accepted and must be held by the source.
- `in_valid` and `in_data` are sampled only on the accept edge. Later changes have no effect on the word in flight.
- `out_ready` is ignored outside DONE.

## Timing
- Reset is active when `rst_n`=0 at a rising edge. Reset values:
  - state = IDLE.
  - `out_valid`=0, `out_data`=0, `out_err_mask`=0, `out_err`=0, `out_bin`=0.
  - `in_ready` is forced to 0 while `rst_n`=0 and is 1 from the first cycle after release.
- Reset mid-operation, in CONV or DONE, aborts. The word is discarded and never presented.
- Latency: the word is accepted at edge k and `out_valid` rises after edge k+DIGITS.
- Throughput: at best one word per DIGITS+2 cycles. That is DIGITS CONV cycles, one DONE cycle with `out_ready`=1, and one IDLE accept cycle.
- `out_valid`, once high, stays high until the edge at which `out_ready`=1.
- DIGITS=1 is legal: a single CONV cycle, then DONE.

## Configuration
- Macro: `BCD_BIN_EN`.
- Defined:
  - Adds port `out_bin` and an accumulator. In CONV each cycle, acc = acc·10 + v, computed in BIN_W bits.
  - If any digit of the word is invalid, `out_bin` is 0 in DONE.
  - `out_bin` is updated together with `out_data`.
- Undefined: no `out_bin` port and no accumulator or multiplier logic. All other behaviour is identical.

## Test plan
All scenarios use DIGITS=4 and BIN_W=14.
- Canonical codes: `in_data`=16'hDCB3 → `out_data`=16'h9872, `out_err`=0, `out_bin`=9872. `out_valid` rises 4 edges after accept.
- Redundant codes: `in_data`=16'h0236 → `out_data`=16'h0124, `out_err_mask`=4'b0000, `out_bin`=124.
- Invalid digit: `in_data`=16'hF000 → `out_data`=16'hF000, `out_err_mask`=4'b1000, `out_err`=1, `out_bin`=0. Then 16'hEEEE → 16'h9999, `out_bin`=9999.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while `in_valid`=1 with a new word. Outputs must stay stable and `in_ready` must stay 0. Release `out_ready`: the new word is accepted in the next IDLE cycle and converted correctly.
- Reset mid-conversion: drive `rst_n`=0 for 1 cycle, 2 cycles after accept. Afterwards `out_valid`=0, all outputs are 0, and `in_ready`=1 on the cycle after release. The next word converts normally.
- Compile without `BCD_BIN_EN`: the first three scenarios give identical `out_data` and `out_err_mask` results.

Source files
------------

// File: rtl/bcd5311_serial_conv.sv
// Serial BCD 5311 -> 8421 converter, one digit per clock, MSD first, valid/ready on both sides.
// Optional binary output: define BCD_BIN_EN to add out_bin and its decimal accumulator.
module bcd5311_serial_conv #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err
`ifdef BCD_BIN_EN
    ,
    output logic [BIN_W-1:0]      out_bin
`endif
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    res_q,   res_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic [3:0]      dig;
    logic [3:0]      dig_v;
    logic            dig_bad;
    logic [3:0]      dig_out;

`ifdef BCD_BIN_EN
    logic [BIN_W-1:0] acc_q, acc_d;
`else
    logic unused_bin_w;
    assign unused_bin_w = |BIN_W;
`endif

    // Weighted decode of the MSD-side nibble; only 1111 sums to 10.
    always_comb begin
        dig     = shift_q[W-1 -: 4];
        dig_v   = (dig[3] ? 4'd5 : 4'd0) + (dig[2] ? 4'd3 : 4'd0)
                + {3'b000, dig[1]} + {3'b000, dig[0]};
        dig_bad = (dig_v > 4'd9);
        dig_out = dig_bad ? 4'hF : dig_v;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        res_d     = res_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
`ifdef BCD_BIN_EN
        acc_d     = acc_q;
`endif
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    res_d   = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
`ifdef BCD_BIN_EN
                    acc_d   = '0;
`endif
                    state_d = CONV;
                end
            end
            CONV: begin
                shift_d = shift_q << 4;
                res_d   = (res_q << 4) | W'(dig_out);
                mask_d  = (mask_q << 1) | DIGITS'(dig_bad);
                cnt_d   = cnt_q + CW'(1);
`ifdef BCD_BIN_EN
                acc_d   = acc_q * BIN_W'(4'd10) + BIN_W'(dig_v);
`endif
                if (cnt_q == CW'(DIGITS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            res_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
`ifdef BCD_BIN_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            res_q   <= res_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
`ifdef BCD_BIN_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign out_data     = res_q;
    assign out_err_mask = mask_q;
    assign out_err      = |mask_q;
`ifdef BCD_BIN_EN
    // Any invalid digit poisons the whole binary value.
    assign out_bin      = (|mask_q) ? '0 : acc_q;
`endif

endmodule

// File: tb/tb_bcd5311_serial_conv.sv
// Directed self-checking bench for bcd5311_serial_conv (DIGITS=4, BIN_W=14).
// out_bin checks are included only when BCD_BIN_EN is defined.
module tb_bcd5311_serial_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_err_mask;
    logic        out_err;
    logic [13:0] out_bin;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bcd5311_serial_conv #(
        .DIGITS (4),
        .BIN_W  (14)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err_mask (out_err_mask),
        .out_err      (out_err)
`ifdef BCD_BIN_EN
        ,
        .out_bin      (out_bin)
`endif
    );

`ifndef BCD_BIN_EN
    assign out_bin = '0;
`endif

    // Offer a word, wait (bounded) for acceptance, then scramble the inputs.
    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
    endtask

    // Edges from the accept edge until out_valid is seen (capped at 20).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({out_data, out_err_mask, out_err} !== 21'd0)
            $display("FAIL reset_outputs got=%h/%b/%b exp=0", out_data, out_err_mask, out_err);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%0b exp=1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_canonical();
        int lat;
        send_word(16'hDCB3);
        wait_done(lat);
        total_cnt++;
        if (lat !== 4) $display("FAIL canon_latency got=%0d exp=4", lat);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h9872) $display("FAIL canon_data got=%h exp=9872", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_err !== 1'b0 || out_err_mask !== 4'b0000)
            $display("FAIL canon_err got=%b/%b exp=0/0000", out_err, out_err_mask);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL canon_in_ready_done got=%0b exp=0", in_ready);
        else pass_cnt++;
`ifdef BCD_BIN_EN
        total_cnt++;
        if (out_bin !== 14'd9872) $display("FAIL canon_bin got=%0d exp=9872", out_bin);
        else pass_cnt++;
`endif
        release_out();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL canon_valid_drop got=%0b exp=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_redundant();
        int lat;
        send_word(16'h0236);
        wait_done(lat);
        total_cnt++;
        if (out_data !== 16'h0124) $display("FAIL redund_data got=%h exp=0124", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_err_mask !== 4'b0000) $display("FAIL redund_mask got=%b exp=0000", out_err_mask);
        else pass_cnt++;
`ifdef BCD_BIN_EN
        total_cnt++;
        if (out_bin !== 14'd124) $display("FAIL redund_bin got=%0d exp=124", out_bin);
        else pass_cnt++;
`endif
        release_out();
    endtask

    task automatic test_invalid();
        int lat;
        send_word(16'hF000);
        wait_done(lat);
        total_cnt++;
        if (out_data !== 16'hF000) $display("FAIL inval_data got=%h exp=F000", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_err_mask !== 4'b1000) $display("FAIL inval_mask got=%b exp=1000", out_err_mask);
        else pass_cnt++;
        total_cnt++;
        if (out_err !== 1'b1) $display("FAIL inval_err got=%0b exp=1", out_err);
        else pass_cnt++;
`ifdef BCD_BIN_EN
        total_cnt++;
        if (out_bin !== 14'd0) $display("FAIL inval_bin got=%0d exp=0", out_bin);
        else pass_cnt++;
`endif
        release_out();
        send_word(16'hEEEE);
        wait_done(lat);
        total_cnt++;
        if (out_data !== 16'h9999) $display("FAIL max_data got=%h exp=9999", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_err_mask !== 4'b0000 || out_err !== 1'b0)
            $display("FAIL max_err got=%b/%b exp=0000/0", out_err_mask, out_err);
        else pass_cnt++;
`ifdef BCD_BIN_EN
        total_cnt++;
        if (out_bin !== 14'd9999) $display("FAIL max_bin got=%0d exp=9999", out_bin);
        else pass_cnt++;
`endif
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        send_word(16'h1234);
        wait_done(lat);
        in_data  = 16'h8421;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 16'h1123 || in_ready !== 1'b0)
                $display("FAIL bp_hold cyc=%0d got v=%0b d=%h r=%0b exp v=1 d=1123 r=0",
                         i, out_valid, out_data, in_ready);
            else pass_cnt++;
        end
`ifdef BCD_BIN_EN
        total_cnt++;
        if (out_bin !== 14'd1123) $display("FAIL bp_bin got=%0d exp=1123", out_bin);
        else pass_cnt++;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_idle got r=%0b v=%0b exp r=1 v=0", in_ready, out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        wait_done(lat);
        total_cnt++;
        if (lat !== 4) $display("FAIL bp_latency got=%0d exp=4", lat);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h5311) $display("FAIL bp_data got=%h exp=5311", out_data);
        else pass_cnt++;
`ifdef BCD_BIN_EN
        total_cnt++;
        if (out_bin !== 14'd5311) $display("FAIL bp_bin2 got=%0d exp=5311", out_bin);
        else pass_cnt++;
`endif
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen_valid;
        send_word(16'hDCB3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rmid_ready_in_reset got=%0b exp=0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({out_valid, out_data, out_err_mask, out_err} !== 22'd0)
            $display("FAIL rmid_outputs got=%b/%h/%b/%b exp=0", out_valid, out_data,
                     out_err_mask, out_err);
        else pass_cnt++;
`ifdef BCD_BIN_EN
        total_cnt++;
        if (out_bin !== 14'd0) $display("FAIL rmid_bin got=%0d exp=0", out_bin);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rmid_ready_after got=%0b exp=1", in_ready);
        else pass_cnt++;
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        total_cnt++;
        if (seen_valid !== 1'b0) $display("FAIL rmid_aborted got=%0b exp=0", seen_valid);
        else pass_cnt++;
        send_word(16'h0236);
        wait_done(lat);
        total_cnt++;
        if (lat !== 4 || out_data !== 16'h0124)
            $display("FAIL rmid_next got lat=%0d d=%h exp lat=4 d=0124", lat, out_data);
        else pass_cnt++;
        release_out();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_canonical();
        test_redundant();
        test_invalid();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
